// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned SB_REG_W = 8;
  localparam int unsigned FWD_W    = 2;

  localparam logic [FWD_W-1:0] FWD_RF = 2'd0;

  // wr_reg is sized for the widest supported register file; narrower files zero-extend
  typedef struct packed {
    logic                valid;
    logic                is_load;
    logic [SB_REG_W-1:0] wr_reg;
  } sb_entry_t;

  function automatic logic [FWD_W-1:0] fwd_code(input int unsigned k);
    return FWD_W'(k + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: master is the pipeline/decode, slave is the hazard unit.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 3
);
  logic              id_valid;
  logic              id_rs_en;
  logic [REG_AW-1:0] id_rs;
  logic              id_rt_en;
  logic [REG_AW-1:0] id_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_reg;
  logic              id_is_load;
  logic              id_halt;
  logic              br_taken_raw;
  logic              ext_stall;
  logic              if_id_nowrite;
  logic              push_nop;
  logic              if_flush;
  logic              branch_taken;
  logic              halt;
  logic [FWD_W-1:0]  fwd_rs_sel;
  logic [FWD_W-1:0]  fwd_rt_sel;
  logic              err;

  modport master (
    output id_valid, id_rs_en, id_rs, id_rt_en, id_rt, id_wr_en, id_wr_reg,
           id_is_load, id_halt, br_taken_raw, ext_stall,
    input  if_id_nowrite, push_nop, if_flush, branch_taken, halt,
           fwd_rs_sel, fwd_rt_sel, err
  );

  modport slave (
    input  id_valid, id_rs_en, id_rs, id_rt_en, id_rt, id_wr_en, id_wr_reg,
           id_is_load, id_halt, br_taken_raw, ext_stall,
    output if_id_nowrite, push_nop, if_flush, branch_taken, halt,
           fwd_rs_sel, fwd_rt_sel, err
  );
endinterface

// File: rtl/hazard_scoreboard_stall_watchdog.sv
// Counts consecutive stall/freeze cycles and raises a sticky error once a stall outlives the limit.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  output logic o_err
);
  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Counter saturates at the limit; a further stalled cycle sets the error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_stall) begin
      if (r_cnt == CNT_W'(STALL_TIMEOUT)) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit with a shift-register scoreboard of in-flight destinations.
// Optional build macro HAZARD_FORWARD_EN: operand forwarding, only load-use stalls remain.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW        = 3,
  parameter int unsigned PIPE_DEPTH    = 2,
  parameter int unsigned STALL_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz_if
);
  sb_entry_t             r_sb [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] w_rs_match;
  logic [PIPE_DEPTH-1:0] w_rt_match;
  logic                  w_hz;
  logic                  w_go;
  logic                  w_err;
  logic [FWD_W-1:0]      w_rs_fwd;
  logic [FWD_W-1:0]      w_rt_fwd;
  sb_entry_t             w_issue;
  logic                  w_unused_ld;

  // Source match against every entry; reset presents an empty scoreboard
  always_comb begin
    w_rs_match  = '0;
    w_rt_match  = '0;
    w_unused_ld = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      w_rs_match[k] = hz_if.id_rs_en & r_sb[k].valid & ~rst &
                      (r_sb[k].wr_reg == SB_REG_W'(hz_if.id_rs));
      w_rt_match[k] = hz_if.id_rt_en & r_sb[k].valid & ~rst &
                      (r_sb[k].wr_reg == SB_REG_W'(hz_if.id_rt));
      w_unused_ld   = w_unused_ld ^ r_sb[k].is_load;
    end
  end

  always_comb begin
    w_hz     = 1'b0;
    w_rs_fwd = FWD_RF;
    w_rt_fwd = FWD_RF;
`ifdef HAZARD_FORWARD_EN
    w_hz = hz_if.id_valid & (w_rs_match[0] | w_rt_match[0]) & r_sb[0].is_load;
    // Walk oldest to youngest so the youngest producer wins
    for (int unsigned k = PIPE_DEPTH; k > 0; k--) begin
      if (w_rs_match[k-1]) w_rs_fwd = fwd_code(k - 1);
      if (w_rt_match[k-1]) w_rt_fwd = fwd_code(k - 1);
    end
`else
    w_hz = hz_if.id_valid & ((|w_rs_match) | (|w_rt_match));
`endif
  end

  always_comb begin
    w_issue         = '0;
    w_issue.valid   = hz_if.id_valid & hz_if.id_wr_en;
    w_issue.is_load = hz_if.id_is_load;
    w_issue.wr_reg  = SB_REG_W'(hz_if.id_wr_reg);
  end

  // Scoreboard shifts every unfrozen cycle; a stalled decode inserts a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) r_sb[k] <= '0;
    end else if (!hz_if.ext_stall) begin
      for (int unsigned k = PIPE_DEPTH - 1; k > 0; k--) r_sb[k] <= r_sb[k-1];
      r_sb[0] <= w_hz ? '0 : w_issue;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .i_stall(w_hz | hz_if.ext_stall),
    .o_err  (w_err)
  );

  // Branch and halt are only honoured for an instruction that actually leaves decode
  always_comb begin
    w_go                = hz_if.id_valid & ~w_hz & ~hz_if.ext_stall & ~rst;
    hz_if.if_id_nowrite = w_hz | hz_if.ext_stall;
    hz_if.push_nop      = w_hz & ~hz_if.ext_stall;
    hz_if.branch_taken  = hz_if.br_taken_raw & w_go;
    hz_if.if_flush      = hz_if.br_taken_raw & w_go;
    hz_if.halt          = hz_if.id_halt & w_go;
    hz_if.fwd_rs_sel    = w_rs_fwd;
    hz_if.fwd_rt_sel    = w_rt_fwd;
    hz_if.err           = w_err;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic vs a queue model.
module tb_hazard_scoreboard;
  localparam int unsigned REG_AW        = 3;
  localparam int unsigned PIPE_DEPTH    = 2;
  localparam int unsigned STALL_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW)) hz_if ();

  hazard_scoreboard #(
    .REG_AW       (REG_AW),
    .PIPE_DEPTH   (PIPE_DEPTH),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hz_if(hz_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of the last PIPE_DEPTH issue slots, youngest first
  typedef struct {
    bit v;
    bit ld;
    int r;
  } slot_t;
  slot_t sb[$];
  int    run   = 0;
  bit    m_err = 1'b0;

  function automatic void model_eval(output bit hz, output int fs, output int ft);
    bit load_use;
    hz = 1'b0; fs = 0; ft = 0; load_use = 1'b0;
    if (rst) return;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].v && hz_if.id_rs_en && sb[k].r == int'(hz_if.id_rs)) fs = k + 1;
      if (sb[k].v && hz_if.id_rt_en && sb[k].r == int'(hz_if.id_rt)) ft = k + 1;
    end
    load_use = (fs == 1 || ft == 1) && sb[0].ld;
`ifdef HAZARD_FORWARD_EN
    hz = hz_if.id_valid && load_use;
`else
    hz = hz_if.id_valid && (fs != 0 || ft != 0);
    fs = 0; ft = 0;
`endif
  endfunction

  always @(posedge clk) begin
    bit    hz;
    int    fs, ft;
    slot_t s;
    model_eval(hz, fs, ft);
    if (rst) begin
      sb.delete();
      run   = 0;
      m_err = 1'b0;
    end else begin
      if (hz || hz_if.ext_stall) begin
        run++;
        if (run > int'(STALL_TIMEOUT)) m_err = 1'b1;
      end else begin
        run = 0;
      end
      if (!hz_if.ext_stall) begin
        s.v  = !hz && hz_if.id_valid && hz_if.id_wr_en;
        s.ld = hz_if.id_is_load;
        s.r  = int'(hz_if.id_wr_reg);
        sb.push_front(s);
        if (sb.size() > int'(PIPE_DEPTH)) void'(sb.pop_back());
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    bit hz, go;
    int fs, ft;
    model_eval(hz, fs, ft);
    go = hz_if.id_valid && !hz && !hz_if.ext_stall && !rst;
    chk("cmp_nowrite", 8'(hz_if.if_id_nowrite), 8'(hz || hz_if.ext_stall));
    chk("cmp_push_nop", 8'(hz_if.push_nop), 8'(hz && !hz_if.ext_stall));
    chk("cmp_branch", 8'(hz_if.branch_taken), 8'(go && hz_if.br_taken_raw));
    chk("cmp_flush", 8'(hz_if.if_flush), 8'(go && hz_if.br_taken_raw));
    chk("cmp_halt", 8'(hz_if.halt), 8'(go && hz_if.id_halt));
    chk("cmp_fwd_rs", 8'(hz_if.fwd_rs_sel), 8'(fs));
    chk("cmp_fwd_rt", 8'(hz_if.fwd_rt_sel), 8'(ft));
    chk("cmp_err", 8'(hz_if.err), 8'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit rs_en, input int rs, input bit rt_en, input int rt,
                       input bit wr_en, input int wr, input bit ld);
    hz_if.id_valid     = v;
    hz_if.id_rs_en     = rs_en;
    hz_if.id_rs        = REG_AW'(rs);
    hz_if.id_rt_en     = rt_en;
    hz_if.id_rt        = REG_AW'(rt);
    hz_if.id_wr_en     = wr_en;
    hz_if.id_wr_reg    = REG_AW'(wr);
    hz_if.id_is_load   = ld;
    hz_if.id_halt      = 1'b0;
    hz_if.br_taken_raw = 1'b0;
    hz_if.ext_stall    = 1'b0;
  endtask

  task automatic randomize_inputs(input bit allow_ext);
    hz_if.id_valid     = ($urandom_range(0, 9) < 8);
    hz_if.id_rs_en     = $urandom_range(0, 1);
    hz_if.id_rs        = REG_AW'($urandom_range(0, 7));
    hz_if.id_rt_en     = $urandom_range(0, 1);
    hz_if.id_rt        = REG_AW'($urandom_range(0, 7));
    hz_if.id_wr_en     = ($urandom_range(0, 9) < 6);
    hz_if.id_wr_reg    = REG_AW'($urandom_range(0, 7));
    hz_if.id_is_load   = ($urandom_range(0, 9) < 3);
    hz_if.id_halt      = ($urandom_range(0, 19) == 0);
    hz_if.br_taken_raw = ($urandom_range(0, 4) == 0);
    hz_if.ext_stall    = allow_ext && ($urandom_range(0, 9) == 0);
  endtask

  task automatic flush_pipe();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

`ifdef HAZARD_FORWARD_EN
  localparam int H = 1;
`else
  localparam int H = 2;
`endif

  initial begin
    // Reset with random inputs, no freeze
    rst = 1'b1;
    randomize_inputs(1'b0);
    look();
    chk("rst_nowrite", 8'(hz_if.if_id_nowrite), 8'd0);
    chk("rst_push_nop", 8'(hz_if.push_nop), 8'd0);
    chk("rst_branch", 8'(hz_if.branch_taken), 8'd0);
    chk("rst_halt", 8'(hz_if.halt), 8'd0);
    step();
    randomize_inputs(1'b0);
    look();
    chk("rst_err", 8'(hz_if.err), 8'd0);
    chk("rst_fwd_rs", 8'(hz_if.fwd_rs_sel), 8'd0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    look();
    chk("post_rst_nowrite", 8'(hz_if.if_id_nowrite), 8'd0);
    chk("post_rst_err", 8'(hz_if.err), 8'd0);
    drive(1, 1, 3, 1, 5, 0, 0, 0);
    look();
    chk("post_rst_empty_sb", 8'(hz_if.push_nop), 8'd0);

    // Back-to-back dependency on r3
    flush_pipe();
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    look();
    chk("raw_producer_push", 8'(hz_if.push_nop), 8'd0);
    step();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
    look();
    chk("raw_fwd_push", 8'(hz_if.push_nop), 8'd0);
    chk("raw_fwd_rs_sel", 8'(hz_if.fwd_rs_sel), 8'd1);
`else
    for (int i = 0; i < 2; i++) begin
      look();
      chk("raw_stall_push", 8'(hz_if.push_nop), 8'd1);
      step();
    end
    look();
    chk("raw_issue_push", 8'(hz_if.push_nop), 8'd0);
    chk("raw_issue_nowrite", 8'(hz_if.if_id_nowrite), 8'd0);
`endif

    // One unrelated instruction between producer and consumer
    flush_pipe();
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    step();
    drive(1, 0, 0, 0, 0, 1, 5, 0);
    step();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    look();
`ifdef HAZARD_FORWARD_EN
    chk("gap_fwd_push", 8'(hz_if.push_nop), 8'd0);
    chk("gap_fwd_rs_sel", 8'(hz_if.fwd_rs_sel), 8'd2);
`else
    chk("gap_stall_push", 8'(hz_if.push_nop), 8'd1);
    step();
    look();
    chk("gap_issue_push", 8'(hz_if.push_nop), 8'd0);
`endif

    // Load then rt consumer
    flush_pipe();
    drive(1, 0, 0, 0, 0, 1, 3, 1);
    step();
    drive(1, 0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < H; i++) begin
      look();
      chk("ld_use_push", 8'(hz_if.push_nop), 8'd1);
      step();
    end
    look();
    chk("ld_use_issue_push", 8'(hz_if.push_nop), 8'd0);
`ifdef HAZARD_FORWARD_EN
    chk("ld_use_fwd_rt_sel", 8'(hz_if.fwd_rt_sel), 8'd2);
`endif

    // Branch and halt held off by a hazard
    flush_pipe();
    drive(1, 0, 0, 0, 0, 1, 3, H == 1);
    step();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    hz_if.br_taken_raw = 1'b1;
    hz_if.id_halt      = 1'b1;
    for (int i = 0; i < H; i++) begin
      look();
      chk("br_hz_branch", 8'(hz_if.branch_taken), 8'd0);
      chk("br_hz_halt", 8'(hz_if.halt), 8'd0);
      step();
    end
    look();
    chk("br_clear_branch", 8'(hz_if.branch_taken), 8'd1);
    chk("br_clear_flush", 8'(hz_if.if_flush), 8'd1);
    chk("br_clear_halt", 8'(hz_if.halt), 8'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    look();
    chk("br_after_branch", 8'(hz_if.branch_taken), 8'd0);

    // Freeze with a pending write keeps the stall length intact
    flush_pipe();
    drive(1, 0, 0, 0, 0, 1, 3, H == 1);
    step();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    hz_if.ext_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("frz_push", 8'(hz_if.push_nop), 8'd0);
      chk("frz_nowrite", 8'(hz_if.if_id_nowrite), 8'd1);
      step();
    end
    hz_if.ext_stall = 1'b0;
    for (int i = 0; i < H; i++) begin
      look();
      chk("frz_after_push", 8'(hz_if.push_nop), 8'd1);
      step();
    end
    look();
    chk("frz_issue_push", 8'(hz_if.push_nop), 8'd0);

    // Watchdog: 16 frozen cycles set the sticky error
    flush_pipe();
    hz_if.ext_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      look();
      chk("wd_before", 8'(hz_if.err), 8'd0);
      step();
    end
    hz_if.ext_stall = 1'b0;
    look();
    chk("wd_set", 8'(hz_if.err), 8'd1);
    step();
    look();
    chk("wd_sticky", 8'(hz_if.err), 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    look();
    chk("wd_cleared", 8'(hz_if.err), 8'd0);

    // Randomized traffic including occasional resets and long freezes
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 59) == 0);
      randomize_inputs(1'b1);
      if ((i % 500) > 470) hz_if.ext_stall = 1'b1;
    end
    step();
    look();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
